bnn_neuron_acc: RTL and testbench

- Parametrised binary neuron that evaluates one activation per frame.
- A frame is a run of input beats. For each beat the block counts the bit positions where input and weight agree (XNOR popcount) and adds the count to a running total.
- At frame end the total is compared against a runtime threshold and a 1-bit activation is emitted.
- Sits between the BNN input/weight streamers and the layer output collector; valid/ready handshakes on both sides.

---
 rtl/bnn_neuron_acc.sv | 190 +++++++++++++++++++
 tb/tb_bnn_neuron_acc.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/bnn_neuron_acc.sv
// bnn_neuron_acc: binary neuron, one XNOR-popcount activation per frame.
// Each accepted beat adds popcount(~(in_data ^ in_weight)) to a running sum.
// At frame end the sum is compared against the threshold latched on the first
// beat, and a 1-bit activation is presented on a valid/ready output.
// Optional build macro BNN_NEURON_SCORE_EN adds port out_score (raw final sum).

// One popcount lane: counts matching bit positions in a LANE_W slice.
module bnn_neuron_acc_lane #(
    parameter  int LANE_W = 8,
    localparam int LC_W   = $clog2(LANE_W + 1)
) (
    input  logic [LANE_W-1:0] a,
    input  logic [LANE_W-1:0] b,
    output logic [LC_W-1:0]   cnt
);
    logic [LANE_W-1:0] xn;

    assign xn = ~(a ^ b);

    // sum the match bits of this slice
    always_comb begin
        cnt = '0;
        for (int i = 0; i < LANE_W; i++)
            cnt = cnt + LC_W'(xn[i]);
    end
endmodule

module bnn_neuron_acc #(
    parameter  int DATA_W    = 32,
    parameter  int MAX_BEATS = 16,
    localparam int CNT_W     = $clog2(MAX_BEATS + 1),
    localparam int ACC_W     = $clog2(DATA_W * MAX_BEATS + 1)
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic [CNT_W-1:0]  cfg_beats,
    input  logic [ACC_W-1:0]  cfg_threshold,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic [DATA_W-1:0] in_weight,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_neuron,
`ifdef BNN_NEURON_SCORE_EN
    output logic [ACC_W-1:0]  out_score,
`endif
    output logic              busy
);
    // The beat is split into fixed-width lanes; a ragged last lane is padded
    // with data=0 / weight=1 so the pad bits never count as matches.
    localparam int LANE_W    = 8;
    localparam int NUM_LANES = (DATA_W + LANE_W - 1) / LANE_W;
    localparam int PAD_W     = NUM_LANES * LANE_W;
    localparam int LC_W      = $clog2(LANE_W + 1);
    localparam int PC_W      = $clog2(DATA_W + 1);

    typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_t;

    typedef struct packed {
        logic [CNT_W-1:0] beats;
        logic [ACC_W-1:0] thr;
    } cfg_t;

    state_t                         state, state_nxt;
    cfg_t                           cfg_q;
    logic [ACC_W-1:0]               acc;
    logic [CNT_W-1:0]               cnt;
    logic [PAD_W-1:0]               d_flat, w_flat;
    logic [NUM_LANES-1:0][LC_W-1:0] lane_cnt;
    logic [PC_W-1:0]                pc;
    logic                           accept;
    logic [CNT_W-1:0]               beats_eff;
    logic [ACC_W-1:0]               acc_base;
    logic [ACC_W-1:0]               sum;
    logic [ACC_W-1:0]               thr_use;
    logic                           done_entry;
    logic                           out_hs;

    assign in_ready = (state != DONE);
    assign busy     = (state != IDLE);
    assign accept   = in_valid && in_ready;
    assign out_hs   = (state == DONE) && out_valid && out_ready;

    // pad the beat out to a whole number of lanes
    always_comb begin
        d_flat = '0;
        w_flat = '1;
        d_flat[DATA_W-1:0] = in_data;
        w_flat[DATA_W-1:0] = in_weight;
    end

    for (genvar l = 0; l < NUM_LANES; l++) begin : g_lane
        bnn_neuron_acc_lane #(.LANE_W(LANE_W)) u_lane (
            .a   (d_flat[l*LANE_W +: LANE_W]),
            .b   (w_flat[l*LANE_W +: LANE_W]),
            .cnt (lane_cnt[l])
        );
    end

    // reduce lane counts to the per-beat match count
    always_comb begin
        pc = '0;
        for (int l = 0; l < NUM_LANES; l++)
            pc = pc + PC_W'(lane_cnt[l]);
    end

    // effective frame length from the live config: 0 means 1, clamp to MAX_BEATS
    always_comb begin
        if (cfg_beats == '0)
            beats_eff = CNT_W'(1);
        else if (cfg_beats > CNT_W'(MAX_BEATS))
            beats_eff = CNT_W'(MAX_BEATS);
        else
            beats_eff = cfg_beats;
    end

    // the first beat of a frame starts from zero and uses the live threshold
    always_comb begin
        acc_base = (state == IDLE) ? '0 : acc;
        thr_use  = (state == IDLE) ? cfg_threshold : cfg_q.thr;
        sum      = acc_base + ACC_W'(pc);
    end

    // state register
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_nxt;
    end

    // next-state: frame start, last beat, output handshake
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:
                if (accept)
                    state_nxt = (beats_eff == CNT_W'(1)) ? DONE : ACCUM;
            ACCUM:
                if (accept && (cnt == cfg_q.beats - CNT_W'(1)))
                    state_nxt = DONE;
            DONE:
                if (out_hs)
                    state_nxt = IDLE;
            default:
                state_nxt = IDLE;
        endcase
    end

    assign done_entry = (state != DONE) && (state_nxt == DONE);

    // accumulator, beat counter and config latch
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            acc   <= '0;
            cnt   <= '0;
            cfg_q <= '0;
        end else if (accept) begin
            acc <= sum;
            if (state == IDLE) begin
                cnt         <= CNT_W'(1);
                cfg_q.beats <= beats_eff;
                cfg_q.thr   <= cfg_threshold;
            end else begin
                cnt <= cnt + CNT_W'(1);
            end
        end
    end

    // result registers: set on DONE entry, held until the next DONE entry
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            out_valid  <= 1'b0;
            out_neuron <= 1'b0;
        end else if (done_entry) begin
            out_valid  <= 1'b1;
            out_neuron <= (sum >= thr_use);
        end else if (out_hs) begin
            out_valid  <= 1'b0;
        end
    end

`ifdef BNN_NEURON_SCORE_EN
    // raw final sum, captured alongside out_neuron
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n)        out_score <= '0;
        else if (done_entry) out_score <= sum;
    end
`endif

endmodule

// File: tb/tb_bnn_neuron_acc.sv
// tb_bnn_neuron_acc: scoreboard bench for bnn_neuron_acc (DATA_W=32, MAX_BEATS=16).
// Expected sums are computed from the driven words and queued per frame; the
// monitor pops and compares on each output handshake.
module tb_bnn_neuron_acc;
    localparam int DW = 32;
    localparam int MB = 16;
    localparam int CW = 5;
    localparam int AW = 10;

    logic          clock = 1'b0;
    logic          reset_n = 1'b0;
    logic [CW-1:0] cfg_beats = '0;
    logic [AW-1:0] cfg_threshold = '0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [DW-1:0] in_data = '0;
    logic [DW-1:0] in_weight = '0;
    logic          out_valid;
    logic          out_ready = 1'b1;
    logic          out_neuron;
`ifdef BNN_NEURON_SCORE_EN
    logic [AW-1:0] out_score;
`endif
    logic          busy;

    typedef struct {
        int sum;
        int thr;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;

    bnn_neuron_acc #(.DATA_W(DW), .MAX_BEATS(MB)) dut (
        .clock         (clock),
        .reset_n       (reset_n),
        .cfg_beats     (cfg_beats),
        .cfg_threshold (cfg_threshold),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_data       (in_data),
        .in_weight     (in_weight),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_neuron    (out_neuron),
`ifdef BNN_NEURON_SCORE_EN
        .out_score     (out_score),
`endif
        .busy          (busy)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s act=%0d exp=%0d", tag, act, exp);
        end
    endtask

    // drive one beat and wait (bounded) until it is accepted
    task automatic beat(input logic [DW-1:0] d, input logic [DW-1:0] w,
                        input logic [CW-1:0] cb, input logic [AW-1:0] th);
        int t = 0;
        in_valid = 1'b1; in_data = d; in_weight = w;
        cfg_beats = cb; cfg_threshold = th;
        @(negedge clock);
        while (!in_ready && t < 50) begin
            @(negedge clock);
            t++;
        end
        if (!in_ready) chk("beat_timeout", 0, 1);
        @(posedge clock);
        #1;
        in_valid = 1'b0;
        in_data = $urandom; in_weight = $urandom;
    endtask

    // mode 0 random, 1 all-match, 2 no-match, 3 pc=20 then pc=12.
    // Beats after the first carry scrambled config that must be ignored.
    task automatic run_frame(input int nb, input logic [CW-1:0] cb,
                             input logic [AW-1:0] th, input int mode);
        logic [DW-1:0] da[MB];
        logic [DW-1:0] wa[MB];
        exp_t e;
        e.sum = 0;
        e.thr = int'(th);
        for (int i = 0; i < nb; i++) begin
            case (mode)
                1: begin da[i] = '1; wa[i] = '1; end
                2: begin da[i] = '0; wa[i] = '1; end
                3: begin da[i] = (i == 0) ? 32'h000F_FFFF : 32'h0000_0FFF; wa[i] = '1; end
                default: begin da[i] = $urandom; wa[i] = $urandom; end
            endcase
            e.sum += $countones(~(da[i] ^ wa[i]));
        end
        sb.push_back(e);
        for (int i = 0; i < nb; i++)
            beat(da[i], wa[i], (i == 0) ? cb : ~cb, (i == 0) ? th : ~th);
    endtask

    task automatic drain();
        int t = 0;
        while ((sb.size() != 0 || out_valid) && t < 100) begin
            @(negedge clock);
            t++;
        end
        if (t >= 100) chk("drain_timeout", 0, 1);
        @(posedge clock);
        #1;
    endtask

    // scoreboard monitor: a result is consumed on valid && ready
    always @(negedge clock) begin
        exp_t e;
        if (reset_n && out_valid && out_ready) begin
            if (sb.size() == 0) begin
                chk("sb_empty", 1, 0);
            end else begin
                e = sb.pop_front();
                chk("neuron", 32'(out_neuron), 32'(e.sum >= e.thr));
`ifdef BNN_NEURON_SCORE_EN
                chk("score", 32'(out_score), 32'(e.sum));
`endif
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL global_timeout act=%0d exp=%0d", 1, 0);
        $fatal(1, "timeout");
    end

    initial begin
        // reset state
        #12;
        chk("rst_valid", 32'(out_valid), 0);
        chk("rst_neuron", 32'(out_neuron), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_ready", 32'(in_ready), 1);
        @(negedge clock);
        reset_n = 1'b1;
        @(posedge clock); #1;

        // 1: single-beat frame, one-cycle latency, in_ready low in DONE
        chk("t1_pre_valid", 32'(out_valid), 0);
        run_frame(1, 5'd1, 10'd16, 1);
        chk("t1_valid", 32'(out_valid), 1);
        chk("t1_in_ready", 32'(in_ready), 0);
        chk("t1_busy", 32'(busy), 1);
        @(posedge clock); #1;
        chk("t1_valid_drop", 32'(out_valid), 0);
        chk("t1_ready_back", 32'(in_ready), 1);

        // 2: all-mismatch frames around threshold 1 / 0
        run_frame(4, 5'd4, 10'd1, 2);
        drain();
        run_frame(4, 5'd4, 10'd0, 2);
        drain();

        // 3: sum 32 at threshold 32 and 33
        run_frame(2, 5'd2, 10'd32, 3);
        drain();
        run_frame(2, 5'd2, 10'd33, 3);
        drain();

        // 5: cfg_beats=0 means one beat; cfg_beats=20 clamps to 16
        run_frame(1, 5'd0, 10'd10, 0);
        chk("t5_zero_done", 32'(out_valid), 1);
        drain();
        run_frame(16, 5'd20, 10'd512, 1);
        chk("t5_clamp_done", 32'(out_valid), 1);
        drain();

        // 4: backpressure holds the result and blocks input
        out_ready = 1'b0;
        run_frame(1, 5'd1, 10'd8, 1);
        in_valid = 1'b1; in_data = '0; in_weight = '1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clock);
            chk("t4_hold_valid", 32'(out_valid), 1);
            chk("t4_hold_neuron", 32'(out_neuron), 1);
            chk("t4_hold_ready", 32'(in_ready), 0);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(posedge clock); #1;
        chk("t4_valid_drop", 32'(out_valid), 0);
        chk("t4_ready_back", 32'(in_ready), 1);
        chk("t4_sb_empty", 32'(sb.size()), 0);

        // 6a: reset mid-frame discards the partial frame
        beat('1, '1, 5'd4, 10'd0);
        beat('1, '1, 5'd4, 10'd0);
        reset_n = 1'b0;
        #2;
        chk("t6_rst_valid", 32'(out_valid), 0);
        chk("t6_rst_neuron", 32'(out_neuron), 0);
        chk("t6_rst_busy", 32'(busy), 0);
        @(negedge clock);
        reset_n = 1'b1;
        @(posedge clock); #1;
        run_frame(4, 5'd4, 10'd64, 0);
        drain();
        run_frame(4, 5'd4, 10'd128, 1);
        drain();

        // 6b: threshold scrambled after the first beat (latched value 100)
        run_frame(4, 5'd4, 10'd100, 0);
        drain();
        run_frame(4, 5'd4, 10'd0, 2);
        drain();

        // a few random frames
        for (int k = 0; k < 6; k++) begin
            int n;
            n = $urandom_range(1, MB);
            run_frame(n, CW'(n), AW'($urandom_range(0, 16 * n + 16)), 0);
            drain();
        end

        chk("final_sb_empty", 32'(sb.size()), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
